// File: rtl/imm_gen_pipe.sv
// Immediate decoder feeding a DEPTH-entry result FIFO; results appear one cycle after the push.
// in_ready depends only on occupancy (never on out_ready); a full buffer refuses pushes.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;

   logic [XLEN-1:0] mem_imm     [DEPTH];
   logic [2:0]      mem_fmt     [DEPTH];
   logic            mem_illegal [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            ready_en;
   logic            push;
   logic            pop;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];

   always_comb begin
      dec_imm     = '0;
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         7'h03, 7'h67: begin
            dec_fmt = FMT_I;
            dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
         end
         7'h13: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               // shift amount only: funct7 bits above the shamt field are dropped
               dec_fmt = FMT_SHAMT;
               if (XLEN == 64) dec_imm = sext32({26'b0, in_instr[25:20]});
               else            dec_imm = sext32({27'b0, in_instr[24:20]});
            end else begin
               dec_fmt = FMT_I;
               dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            end
         end
         7'h23: begin
            dec_fmt = FMT_S;
            dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
         end
         7'h63: begin
            dec_fmt = FMT_B;
            dec_imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0});
         end
         7'h37, 7'h17: begin
            dec_fmt = FMT_U;
            dec_imm = sext32({in_instr[31:12], 12'b0});
         end
         7'h6F: begin
            dec_fmt = FMT_J;
            dec_imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0});
         end
         7'h33: ;
         default: dec_illegal = 1'b1;
      endcase
   end

   assign out_valid = (count != '0);
   assign in_ready  = ready_en && (count < FULL);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;

   // ready_en keeps in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         ready_en <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm[wr_ptr]     <= dec_imm;
         mem_fmt[wr_ptr]     <= dec_fmt;
         mem_illegal[wr_ptr] <= dec_illegal;
      end
   end

   assign out_imm     = out_valid ? mem_imm[rd_ptr]     : '0;
   assign out_fmt     = out_valid ? mem_fmt[rd_ptr]     : FMT_NONE;
   assign out_illegal = out_valid ? mem_illegal[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream,
// checked against a queue of accepted words decoded with plain integer arithmetic.
module tb_imm_gen_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic        w_in_ready, w_out_valid, w_out_illegal;
   logic [63:0] w_out_imm;
   logic [2:0]  w_out_fmt;

   int errors = 0;
   int checks = 0;

   logic [31:0] q[$];
   bit          m_rdy_en = 1'b0;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal));

   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_instr(in_instr), .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm),
      .out_fmt(w_out_fmt), .out_illegal(w_out_illegal));

   function automatic longint fld(input logic [31:0] w, input int lo, input int n);
      longint v;
      v = longint'(w >> lo);
      return v & ((longint'(1) << n) - 1);
   endfunction

   function automatic void ref_dec(input logic [31:0] w, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] fmt,
                                   output logic ill);
      longint sgn, v;
      sgn = w[31] ? -64'sd1 : 64'sd0;
      v = 0; fmt = 3'd0; ill = 1'b0;
      case (w[6:0])
         7'h03, 7'h67: begin fmt = 3'd1; v = sgn * 4096 + fld(w, 20, 12); end
         7'h13: begin
            if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
               fmt = 3'd6; v = fld(w, 20, (xlen == 64) ? 6 : 5);
            end else begin
               fmt = 3'd1; v = sgn * 4096 + fld(w, 20, 12);
            end
         end
         7'h23: begin fmt = 3'd2; v = sgn * 4096 + fld(w, 25, 7) * 32 + fld(w, 7, 5); end
         7'h63: begin
            fmt = 3'd3;
            v = sgn * 8192 + fld(w, 31, 1) * 4096 + fld(w, 7, 1) * 2048
                + fld(w, 25, 6) * 32 + fld(w, 8, 4) * 2;
         end
         7'h37, 7'h17: begin fmt = 3'd4; v = sgn * 64'sd4294967296 + fld(w, 12, 20) * 4096; end
         7'h6F: begin
            fmt = 3'd5;
            v = sgn * 2097152 + fld(w, 31, 1) * 1048576 + fld(w, 12, 8) * 4096
                + fld(w, 20, 1) * 2048 + fld(w, 21, 10) * 2;
         end
         7'h33: ;
         default: ill = 1'b1;
      endcase
      imm = v;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [6:0]  ops [9];
      logic [31:0] w;
      int          k;
      ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = ops[k];
      return w;
   endfunction

   // advance the reference model across the coming edge, then move to edge+1
   task automatic tick();
      bit push, pop;
      if (!rst_n) begin
         q.delete();
         m_rdy_en = 1'b0;
      end else begin
         push = in_valid && m_rdy_en && (q.size() < 2) && !flush;
         pop  = out_ready && (q.size() > 0);
         if (flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(in_instr);
         end
         m_rdy_en = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_imm, out_fmt, out_illegal, w_out_imm} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b vld=%b imm=%h fmt=%0d ill=%b imm64=%h, all zero expected",
                  in_ready, out_valid, out_imm, out_fmt, out_illegal, w_out_imm);
      end
      tick();
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL ready_before_edge: got %b expected 0", in_ready);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_edge: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_i_format();
      in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_imm, out_fmt, out_illegal} !== {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL i_format: vld=%b imm=%h fmt=%0d ill=%b expected 1 ffffffff 1 0",
                  out_valid, out_imm, out_fmt, out_illegal);
      end
      checks++;
      if (w_out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++; $display("FAIL i_format64: got %h expected ffffffffffffffff", w_out_imm);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL i_format_pop: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [3];
      logic [31:0] imms  [3];
      logic [2:0]  fmts  [3];
      words = '{32'h12345037, 32'hFE000EE3, 32'h4030D093};
      imms  = '{32'h12345000, 32'hFFFFFFFC, 32'h00000003};
      fmts  = '{3'd4, 3'd3, 3'd6};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_instr = words[i];
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_imm !== imms[i] || out_fmt !== fmts[i]) begin
            errors++;
            $display("FAIL back_to_back[%0d]: vld=%b imm=%h fmt=%0d expected 1 %h %0d",
                     i, out_valid, out_imm, out_fmt, imms[i], fmts[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL back_to_back_drain: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_full();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
      tick();
      in_instr = 32'h00A00113;
      tick();
      in_instr = 32'hFE000EE3;
      checks++;
      if (in_ready !== 1'b0 || out_imm !== 32'd1) begin
         errors++; $display("FAIL full_ready: in_ready=%b head=%h expected 0 00000001", in_ready, out_imm);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_imm !== 32'd10) begin
         errors++; $display("FAIL full_pop1: in_ready=%b head=%h expected 1 0000000a", in_ready, out_imm);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_fmt !== 3'd3) begin
         errors++;
         $display("FAIL full_third: vld=%b imm=%h fmt=%0d expected 1 fffffffc 3", out_valid, out_imm, out_fmt);
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL full_drain: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F;
      tick();
      in_instr = 32'h00000033;
      checks++;
      if ({out_valid, out_imm, out_fmt, out_illegal} !== {1'b1, 32'h0, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL illegal: vld=%b imm=%h fmt=%0d ill=%b expected 1 0 0 1",
                  out_valid, out_imm, out_fmt, out_illegal);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_imm, out_fmt, out_illegal} !== {1'b1, 32'h0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL r_type: vld=%b imm=%h fmt=%0d ill=%b expected 1 0 0 0",
                  out_valid, out_imm, out_fmt, out_illegal);
      end
      tick();
   endtask

   task automatic test_xlen64();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h80000037;
      tick();
      in_instr = 32'h03F09093;
      checks++;
      if (w_out_imm !== 64'hFFFF_FFFF_8000_0000 || out_imm !== 32'h80000000 || w_out_fmt !== 3'd4) begin
         errors++;
         $display("FAIL lui64: imm64=%h imm32=%h fmt=%0d expected ffffffff80000000 80000000 4",
                  w_out_imm, out_imm, w_out_fmt);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (w_out_imm !== 64'd63 || out_imm !== 32'd31 || w_out_fmt !== 3'd6) begin
         errors++;
         $display("FAIL shamt64: imm64=%h imm32=%h fmt=%0d expected 63 31 6", w_out_imm, out_imm, w_out_fmt);
      end
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
      tick();
      in_instr = 32'h00A00113;
      tick();
      flush = 1'b1; in_instr = 32'h12345037;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL flush_pre: vld=%b rdy=%b expected 1 0", out_valid, in_ready);
      end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || w_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_post[%0d]: vld=%b rdy=%b imm=%h expected 0 1 0", i, out_valid, in_ready, out_imm);
         end
         tick();
      end
      in_valid = 1'b1; in_instr = 32'hFE000EE3;
      tick();
      in_instr = 32'h80000037;
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_imm, out_fmt, out_illegal, w_out_valid, w_out_imm} !== '0) begin
         errors++;
         $display("FAIL async_reset: vld=%b rdy=%b imm=%h fmt=%0d imm64=%h expected all 0",
                  out_valid, in_ready, out_imm, out_fmt, w_out_imm);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      logic [63:0] e32, e64;
      logic [2:0]  ef, ef64;
      logic        ei, ei64, exp_v, exp_r;
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_instr  = rand_word();
         exp_v = (q.size() > 0);
         exp_r = m_rdy_en && (q.size() < 2);
         e32 = '0; e64 = '0; ef = '0; ef64 = '0; ei = 1'b0; ei64 = 1'b0;
         if (q.size() > 0) begin
            ref_dec(q[0], 32, e32, ef, ei);
            ref_dec(q[0], 64, e64, ef64, ei64);
         end
         checks++;
         if ({out_valid, in_ready, out_imm, out_fmt, out_illegal} !== {exp_v, exp_r, e32[31:0], ef, ei}) begin
            errors++;
            $display("FAIL random32[%0d]: vld=%b rdy=%b imm=%h fmt=%0d ill=%b expected %b %b %h %0d %b",
                     n, out_valid, in_ready, out_imm, out_fmt, out_illegal, exp_v, exp_r, e32[31:0], ef, ei);
         end
         checks++;
         if ({w_out_valid, w_out_imm, w_out_fmt, w_out_illegal} !== {exp_v, e64, ef64, ei64}) begin
            errors++;
            $display("FAIL random64[%0d]: vld=%b imm=%h fmt=%0d ill=%b expected %b %h %0d %b",
                     n, w_out_valid, w_out_imm, w_out_fmt, w_out_illegal, exp_v, e64, ef64, ei64);
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_i_format();
      test_back_to_back();
      test_full();
      test_illegal();
      test_xlen64();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
